// File: rtl/cpu_dcache_write_buffer_if.sv
// CPU-port and bus-port signals of the data-cache posted-write buffer.
//
// Handshake semantics (both sides): a requester raises *_request together
// with direction, address and write data and holds all of them stable until
// the responder pulses its completion strobe (o_ready on the CPU side,
// i_bus_ready on the bus side). A transfer happens on the rising clock edge
// where request and strobe are both high; read data is valid in that cycle.
interface cpu_dcache_write_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Bus side
  logic                  o_bus_rw;
  logic                  o_bus_request;
  logic                  i_bus_ready;
  logic [ADDR_WIDTH-1:0] o_bus_address;
  logic [DATA_WIDTH-1:0] i_bus_rdata;
  logic [DATA_WIDTH-1:0] o_bus_wdata;

  // CPU side
  logic                  i_rw;
  logic                  i_request;
  logic                  o_ready;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic [DATA_WIDTH-1:0] i_wdata;

  // Buffer control and status
  logic                  i_flush;
  logic                  o_empty;
  logic [CW-1:0]         o_count;

  // The write buffer itself
  modport slave (
    input  i_bus_ready, i_bus_rdata, i_rw, i_request, i_address, i_wdata, i_flush,
    output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    output o_ready, o_rdata, o_empty, o_count
  );

  // The environment around the buffer (CPU plus bus responder)
  modport master (
    output i_bus_ready, i_bus_rdata, i_rw, i_request, i_address, i_wdata, i_flush,
    input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    input  o_ready, o_rdata, o_empty, o_count
  );
endinterface

// File: rtl/cpu_dcache_write_buffer.sv
// Multi-entry posted-write buffer between the CPU data port and the data bus.
// Writes retire in one cycle into a circular FIFO and drain to the bus in
// order; reads that hit a buffered address are forwarded from the youngest
// matching entry; read misses take the bus ahead of draining unless the
// buffer is full or a flush is requested.
module cpu_dcache_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic       i_clock,
  input  logic       i_reset,
  cpu_dcache_write_buffer_if.slave bus,
  output logic [1:0] o_dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } owner_e;

  owner_e                state_q, state_d, cur;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, hit, rd_start, push, pop;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign full        = (count_q == CW'(DEPTH));
  assign rd_start    = bus.i_request & ~bus.i_rw & ~hit & ~full & ~bus.i_flush;
  assign bus.o_empty = (count_q == '0) && (state_q != DRAIN);
  assign bus.o_count = count_q;
  assign o_dbg_state = state_q;

  // Forwarding search: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (addr_mem[head_q + PW'(k)] == bus.i_address)) begin
        hit      = 1'b1;
        fwd_data = data_mem[head_q + PW'(k)];
      end
    end
  end

  // Bus owner decision, bus outputs, CPU completion and FIFO push/pop.
  always_comb begin
    cur               = IDLE;
    state_d           = state_q;
    push              = 1'b0;
    pop               = 1'b0;
    count_d           = count_q;
    bus.o_bus_rw      = 1'b0;
    bus.o_bus_request = 1'b0;
    bus.o_bus_address = '0;
    bus.o_bus_wdata   = '0;
    bus.o_ready       = 1'b0;
    bus.o_rdata       = '0;
    if (i_reset) begin
      // An idle owner decides in the same cycle so no bus cycle is lost.
      cur = state_q;
      if (state_q == IDLE) begin
        if (rd_start)            cur = READ;
        else if (count_q != '0)  cur = DRAIN;
      end

      case (cur)
        READ: begin
          bus.o_bus_request = 1'b1;
          bus.o_bus_address = bus.i_address;
          if (bus.i_bus_ready) begin
            bus.o_ready = 1'b1;
            bus.o_rdata = bus.i_bus_rdata;
            state_d     = IDLE;
          end else begin
            state_d = READ;
          end
        end
        DRAIN: begin
          bus.o_bus_request = 1'b1;
          bus.o_bus_rw      = 1'b1;
          bus.o_bus_address = addr_mem[head_q];
          bus.o_bus_wdata   = data_mem[head_q];
          pop               = bus.i_bus_ready;
        end
        default: state_d = IDLE;
      endcase

      // CPU side: writes need space by the registered count; hits forward.
      if (cur != READ) begin
        if (bus.i_request && bus.i_rw && !full && !bus.i_flush) begin
          push        = 1'b1;
          bus.o_ready = 1'b1;
        end else if (bus.i_request && !bus.i_rw && hit) begin
          bus.o_ready = 1'b1;
          bus.o_rdata = fwd_data;
        end
      end

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      // A drain keeps the bus while anything is left after this cycle.
      if (cur == DRAIN) state_d = (!pop || count_d != '0) ? DRAIN : IDLE;
    end
  end

  // Owner state, pointers and entry count.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
    end
  end

  // Entry storage; validity is implied by head and count, so no reset needed.
  always_ff @(posedge i_clock) begin
    if (push) begin
      addr_mem[tail_q] <= bus.i_address;
      data_mem[tail_q] <= bus.i_wdata;
    end
  end
endmodule

// File: doc/cpu_dcache_write_buffer.md
Name: cpu_dcache_write_buffer

Overview:
- Parametrised multi-entry posted-write buffer between the CPU data port and the data bus; successor to the single-entry write-back stage.
- Writes retire in 1 cycle into a FIFO and drain to the bus in order.
- Reads hitting a buffered address are forwarded from the youngest matching entry.
- Read misses go to the bus ahead of draining unless the buffer is full or a flush is pending.

Parameters:
DEPTH, 4, number of posted-write entries (power of two, >= 2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (whole-word writes only)

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous active-low reset
o_bus_rw  out  1  bus direction, 1 = write
o_bus_request  out  1  bus request
i_bus_ready  in  1  bus completion strobe for the current request
o_bus_address  out  ADDR_WIDTH  bus address
i_bus_rdata  in  DATA_WIDTH  bus read data
o_bus_wdata  out  DATA_WIDTH  bus write data
i_rw  in  1  CPU direction, 1 = write
i_request  in  1  CPU request
o_ready  out  1  CPU completion strobe
i_address  in  ADDR_WIDTH  CPU address
o_rdata  out  DATA_WIDTH  CPU read data
i_wdata  in  DATA_WIDTH  CPU write data
i_flush  in  1  level request: drain the buffer with reads blocked
o_empty  out  1  buffer holds no entries and no drain is in flight
o_count  out  $clog2(DEPTH)+1  registered entry count

Behaviour:
- Reset (i_reset=0, asynchronous):
  - All entries are discarded; count=0; bus owner=IDLE.
  - Outputs: o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0, o_ready=0, o_rdata=0, o_empty=1, o_count=0.
  - An in-flight bus transaction is abandoned.
- Storage: circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Count is a separate register. Full = (count==DEPTH).
- Bus owner FSM, states IDLE, DRAIN, READ:
  - A transaction, once started, holds request/address/rw/wdata stable until i_bus_ready. No preemption.
  - IDLE -> READ: i_request & !i_rw & no forward hit & !full & !i_flush. This has priority over draining.
  - IDLE -> DRAIN: count>0 and the READ condition is false.
  - READ: o_bus_rw=0, o_bus_address=i_address, o_rdata=i_bus_rdata, o_ready=i_bus_ready. On i_bus_ready -> IDLE.
  - DRAIN: o_bus_rw=1, address/data taken from the head entry. On i_bus_ready: pop the head, then go to DRAIN if count after the pop > 0, else IDLE.
  - Bus outputs are combinational from owner state and head. In IDLE they are 0.
  - The IDLE decision drives o_bus_request combinationally in the same cycle, giving 0 idle cycles.
- CPU write (i_request & i_rw):
  - If !full (registered count), push at tail and assert o_ready=1 the same cycle.
  - If full, o_ready=0 and the CPU holds.
  - A pop in the same cycle does not free space for that cycle.
  - No coalescing: a repeated address pushes a new entry.
- CPU read, forward hit:
  - Compare i_address against all valid entries, including the head while it is draining.
  - On a match, o_rdata = data of the youngest match and o_ready=1 the same cycle. No bus access.
  - The bus state is unaffected.
- CPU read, miss:
  - Served via READ when it is legal.
  - Otherwise o_ready=0 until the buffer drains or the bus frees.
  - The read must not start while its address matches any entry (guaranteed, since a match means a hit).
- Simultaneous events:
  - Push and pop in one cycle: count unchanged, both pointers advance.
  - Push when count==0 while IDLE: the entry becomes drainable next cycle.
- i_flush:
  - Blocks new READ starts and CPU writes (o_ready=0 for writes).
  - Forward hits are still served.
  - Draining continues until o_empty=1.
- o_empty = (count==0) & (owner != DRAIN), registered-derived.

Test Plan:
- Reset mid-DRAIN: 2 entries, owner DRAIN, pulse i_reset low -> o_bus_request=0 immediately, o_count=0, o_empty=1; after release, no bus writes occur.
- Fill/stall: DEPTH=4, 5 back-to-back writes to 0x100..0x110, i_bus_ready held 0 -> first 4 writes get o_ready=1 in 1 cycle each, 5th stalls. Releasing ready yields bus writes in order 0x100,0x104,0x108,0x10C, then 0x110 is accepted.
- Forwarding: write 0x200=0xAAAA, then 0x200=0xBBBB, then read 0x200 with bus ready held 0 -> o_ready=1 same cycle, o_rdata=0xBBBB, no bus read.
- Read priority: buffer holds 1 entry, owner IDLE, read miss 0x300 -> bus read issued before the drain. After i_bus_ready, o_rdata=i_bus_rdata=0x1234, then the drain of the entry starts the next cycle.
- Pointer wrap: 10 write/drain pairs with DEPTH=4 -> bus sees all 10 addresses in order with matching data; o_count never exceeds 4.
- Flush: 3 entries, i_flush=1, concurrent read miss -> no bus read until o_empty=1. A concurrent write stalls, and a read hit still forwards.
